// File: rtl/dense_seq_pkg.sv
// Shared types and constants for the dense layer sequencer.
// Data words are Q8.24 fixed point.
package dense_seq_pkg;

    localparam int DW        = 32;
    localparam int FRAC_BITS = 24;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        WRITE
    } state_t;

    typedef enum logic [1:0] {
        DUMMY,
        ACT,
        WGT,
        BIAS
    } beat_t;

endpackage

// File: rtl/dense_seq_addr_gen.sv
// Beat sequencing and buffer address generation for one dense layer.
// Weights are walked by a free-running pointer across rows.
module dense_seq_addr_gen
    import dense_seq_pkg::*;
#(
    parameter int AW = 16,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          init,
    input  logic          adv,
    input  logic [AW-1:0] act_base,
    input  logic [AW-1:0] wgt_base,
    input  logic [AW-1:0] bias_base,
    input  logic [LW-1:0] in_len,
    input  logic [LW-1:0] out_len,
    output beat_t         beat,
    output logic [AW-1:0] addr,
    output logic          last_beat,
    output logic          last_neuron
);

    logic [AW-1:0] act_base_q;
    logic [AW-1:0] act_ptr;
    logic [AW-1:0] wgt_ptr;
    logic [AW-1:0] bias_ptr;
    logic [LW-1:0] i_cnt;
    logic [LW-1:0] j_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat       <= DUMMY;
            act_base_q <= '0;
            act_ptr    <= '0;
            wgt_ptr    <= '0;
            bias_ptr   <= '0;
            i_cnt      <= '0;
            j_cnt      <= '0;
        end else if (init) begin
            beat       <= DUMMY;
            act_base_q <= act_base;
            act_ptr    <= act_base;
            wgt_ptr    <= wgt_base;
            bias_ptr   <= bias_base;
            i_cnt      <= '0;
            j_cnt      <= '0;
        end else if (adv) begin
            unique case (beat)
                DUMMY: beat <= ACT;
                ACT: begin
                    beat    <= WGT;
                    act_ptr <= act_ptr + AW'(1);
                end
                WGT: begin
                    wgt_ptr <= wgt_ptr + AW'(1);
                    if (i_cnt == in_len - LW'(1)) begin
                        beat  <= BIAS;
                        i_cnt <= '0;
                    end else begin
                        beat  <= ACT;
                        i_cnt <= i_cnt + LW'(1);
                    end
                end
                BIAS: begin
                    // rewind activations for the next neuron
                    beat     <= DUMMY;
                    act_ptr  <= act_base_q;
                    bias_ptr <= bias_ptr + AW'(1);
                    j_cnt    <= j_cnt + LW'(1);
                end
            endcase
        end
    end

    always_comb begin
        addr = '0;
        unique case (beat)
            DUMMY: addr = '0;
            ACT:   addr = act_ptr;
            WGT:   addr = wgt_ptr;
            BIAS:  addr = bias_ptr;
        endcase
    end

    assign last_beat   = (beat == BIAS);
    assign last_neuron = (j_cnt == out_len - LW'(1));

endmodule

// File: rtl/dense_layer_sequencer.sv
// Streams a dense layer through the single-neuron MAC engine.
// Define DENSE_SEQ_RELU_EN to fuse ReLU into the result write.
module dense_layer_sequencer
    import dense_seq_pkg::*;
#(
    parameter int AW = 16,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [LW-1:0] in_len,
    input  logic [LW-1:0] out_len,
    input  logic [AW-1:0] act_base,
    input  logic [AW-1:0] wgt_base,
    input  logic [AW-1:0] bias_base,
    input  logic [AW-1:0] out_base,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [DW-1:0] acc_data,
    output logic          acc_valid,
    output logic [31:0]   acc_length,
    input  logic [DW-1:0] acc_result
);

    state_t        state;
    state_t        state_nxt;
    beat_t         beat;
    beat_t         pres_beat;
    logic [AW-1:0] gen_addr;
    logic          last_beat;
    logic          last_neuron;
    logic          accept;
    logic          cfg_ok;
    logic          init;
    logic          issue;
    logic [LW-1:0] len_l;
    logic [LW-1:0] len_n;
    logic [AW-1:0] out_ptr;
    logic          pres_valid;
    logic          cap_stage;
    logic [DW-1:0] res_q;
    logic          wr_v;
    logic          done_q;
    logic          err_q;
    logic [DW-1:0] wr_res;

    assign accept = (state == IDLE) && start;
    assign cfg_ok = (in_len != '0) && (out_len != '0);
    assign init   = accept && cfg_ok;

    dense_seq_addr_gen #(
        .AW(AW),
        .LW(LW)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .init       (accept),
        .adv        (issue),
        .act_base   (act_base),
        .wgt_base   (wgt_base),
        .bias_base  (bias_base),
        .in_len     (len_l),
        .out_len    (len_n),
        .beat       (beat),
        .addr       (gen_addr),
        .last_beat  (last_beat),
        .last_neuron(last_neuron)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (init) state_nxt = STREAM;
            STREAM: if (last_beat && last_neuron) state_nxt = DRAIN;
            DRAIN:  if (cap_stage) state_nxt = WRITE;
            WRITE:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        issue = (state == STREAM);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pres_valid <= 1'b0;
            pres_beat  <= DUMMY;
            cap_stage  <= 1'b0;
            res_q      <= '0;
            wr_v       <= 1'b0;
            len_l      <= '0;
            len_n      <= '0;
            out_ptr    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pres_valid <= issue;
            pres_beat  <= beat;
            // engine result is valid the cycle after the bias beat
            cap_stage  <= pres_valid && (pres_beat == BIAS);
            if (cap_stage) res_q <= acc_result;
            wr_v       <= cap_stage;
            if (accept) begin
                len_l   <= in_len;
                len_n   <= out_len;
                out_ptr <= out_base;
                err_q   <= !cfg_ok;
            end else if (wr_v) begin
                out_ptr <= out_ptr + AW'(1);
            end
            done_q <= (state == WRITE) || (accept && !cfg_ok);
        end
    end

`ifdef DENSE_SEQ_RELU_EN
    assign wr_res = res_q[DW-1] ? '0 : res_q;
`else
    assign wr_res = res_q;
`endif

    assign done       = done_q;
    assign err        = err_q;
    assign rd_en      = issue && (beat != DUMMY);
    assign rd_addr    = rd_en ? gen_addr : '0;
    assign acc_valid  = pres_valid;
    assign acc_data   = (pres_valid && pres_beat != DUMMY) ? rd_data : '0;
    assign acc_length = 32'(len_l);
    assign wr_en      = wr_v;
    assign wr_addr    = wr_v ? out_ptr : '0;
    assign wr_data    = wr_v ? wr_res : '0;

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Scoreboard bench for dense_layer_sequencer with a behavioural MAC
// engine, buffer memory and layer reference model.
module tb_dense_layer_sequencer;

    localparam int AW = 16;
    localparam int LW = 16;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] in_len = '0;
    logic [LW-1:0] out_len = '0;
    logic [AW-1:0] act_base = '0;
    logic [AW-1:0] wgt_base = '0;
    logic [AW-1:0] bias_base = '0;
    logic [AW-1:0] out_base = '0;
    logic          busy, done, err, rd_en, wr_en, acc_valid;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [31:0]   rd_data = '0;
    logic [31:0]   wr_data, acc_data, acc_length;
    logic [31:0]   acc_result = '0;

    logic [31:0] mem [0:65535];
    logic [15:0] rdq [$];
    wr_t         wrq [$];
    wr_t         mon_w;
    int          n_checks = 0;
    int          n_fail = 0;
    int          proto_err = 0;
    int unsigned ek;
    logic [31:0] ea, eacc;

    always #5 clk = ~clk;

    dense_layer_sequencer #(.AW(AW), .LW(LW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_len(in_len), .out_len(out_len),
        .act_base(act_base), .wgt_base(wgt_base),
        .bias_base(bias_base), .out_base(out_base),
        .busy(busy), .done(done), .err(err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .acc_data(acc_data), .acc_valid(acc_valid),
        .acc_length(acc_length), .acc_result(acc_result)
    );

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] qmul(logic [31:0] a, logic [31:0] w);
        longint p;
        p = longint'($signed(a)) * longint'($signed(w));
        return 32'(p >>> 24);
    endfunction

    function automatic logic [31:0] post(logic [31:0] v);
`ifdef DENSE_SEQ_RELU_EN
        return v[31] ? 32'h0 : v;
`else
        return v;
`endif
    endfunction

    // buffer RAM, one cycle read latency
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    // MAC engine: dummy, a/w pairs, bias; result the cycle after bias
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ek <= 0; ea <= '0; eacc <= '0; acc_result <= '0;
        end else if (acc_valid) begin
            if (ek == 0) begin
                if (acc_data != 0) proto_err <= proto_err + 1;
                eacc <= '0;
                ek <= 1;
            end else if (ek == 2 * acc_length + 1) begin
                acc_result <= eacc + acc_data;
                ek <= 0;
            end else if (ek[0]) begin
                ea <= acc_data;
                ek <= ek + 1;
            end else begin
                eacc <= eacc + qmul(ea, acc_data);
                ek <= ek + 1;
            end
        end else if (ek != 0) begin
            proto_err <= proto_err + 1;
            ek <= 0;
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (reset) begin
            if (rd_en) begin
                if (rdq.size() == 0) chk("rd_unexpected", 64'(rd_addr), 64'hFFFFFFFF);
                else chk("rd_addr", 64'(rd_addr), 64'(rdq.pop_front()));
            end
            if (wr_en) begin
                if (wrq.size() == 0) begin
                    chk("wr_unexpected", 64'(wr_addr), 64'hFFFFFFFF);
                end else begin
                    mon_w = wrq.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(mon_w.a));
                    chk("wr_data", 64'(wr_data), 64'(mon_w.d));
                end
            end
        end
    end

    task automatic chk_zero(input string nm);
        chk({nm, "_ctrl"}, 64'({busy, done, err, rd_en, wr_en, acc_valid}), 64'(0));
        chk({nm, "_data"}, 64'(|{rd_addr, wr_addr, wr_data, acc_data, acc_length}), 64'(0));
    endtask

    task automatic run_job(input int L, input int N, input logic [15:0] ab,
                           input logic [15:0] wb, input logic [15:0] bb,
                           input logic [15:0] ob, input int abort_at,
                           input bit glitch);
        int T, k, av_cnt, av_first, av_last, pe0;
        T = N * (2 * L + 2);
        k = 0; av_cnt = 0; av_first = -1; av_last = -1;
        for (int j = 0; j < N; j++) begin
            logic [31:0] acc;
            logic [15:0] a_ad, w_ad, b_ad;
            acc = '0;
            for (int i = 0; i < L; i++) begin
                a_ad = ab + 16'(i);
                w_ad = wb + 16'(j * L + i);
                rdq.push_back(a_ad);
                rdq.push_back(w_ad);
                acc = acc + qmul(mem[a_ad], mem[w_ad]);
            end
            b_ad = bb + 16'(j);
            rdq.push_back(b_ad);
            acc = acc + mem[b_ad];
            if (abort_at == 0) wrq.push_back(wr_t'{a: ob + 16'(j), d: post(acc)});
        end
        @(negedge clk);
        pe0 = proto_err;
        in_len = 16'(L); out_len = 16'(N);
        act_base = ab; wgt_base = wb; bias_base = bb; out_base = ob;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        chk("busy_after_start", 64'(busy), 64'(1));
        chk("err_clear", 64'(err), 64'(0));
        while (k < T + 12) begin
            if (acc_valid) begin
                av_cnt++;
                if (av_first < 0) av_first = k;
                av_last = k;
            end
            if (done) break;
            if (abort_at == k) begin
                reset = 1'b0;
                @(negedge clk);
                chk_zero("abort_zero");
                repeat (2) @(negedge clk);
                reset = 1'b1;
                rdq.delete();
                wrq.delete();
                return;
            end
            if (glitch && k == 4) begin
                start = 1'b1; in_len = 16'd7; wgt_base = 16'h5555;
            end
            if (glitch && k == 5) begin
                start = 1'b0; in_len = 16'(L); wgt_base = wb;
            end
            @(negedge clk);
            k++;
        end
        chk("done_latency", 64'(k), 64'(T + 4));
        chk("busy_at_done", 64'(busy), 64'(0));
        chk("acc_valid_count", 64'(av_cnt), 64'(T));
        chk("acc_valid_first", 64'(av_first), 64'(2));
        chk("acc_valid_last", 64'(av_last), 64'(T + 1));
        chk("engine_protocol", 64'(proto_err), 64'(pe0));
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'(0));
        chk("rdq_empty", 64'(rdq.size()), 64'(0));
        chk("wrq_empty", 64'(wrq.size()), 64'(0));
    endtask

    task automatic run_zero(input int L, input int N);
        int act;
        act = 0;
        @(negedge clk);
        in_len = 16'(L); out_len = 16'(N);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero_done", 64'(done), 64'(1));
        chk("zero_err", 64'(err), 64'(1));
        chk("zero_busy", 64'(busy), 64'(0));
        repeat (4) begin
            act += int'(rd_en) + int'(acc_valid) + int'(wr_en);
            @(negedge clk);
        end
        chk("zero_activity", 64'(act), 64'(0));
        chk("zero_err_sticky", 64'(err), 64'(1));
        chk("zero_done_pulse", 64'(done), 64'(0));
    endtask

    task automatic fill(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) mem[base + 16'(i)] = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b1;

        mem[16'h0100] = 32'h01000000; mem[16'h0101] = 32'h02000000;
        mem[16'h0200] = 32'h00800000; mem[16'h0201] = 32'h00400000;
        mem[16'h0300] = 32'h01000000;
        run_job(2, 1, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            mem[16'h0110 + 16'(i)] = 32'h01000000;
            mem[16'h0210 + 16'(i)] = 32'h01000000;
            mem[16'h0213 + 16'(i)] = 32'h00800000;
        end
        mem[16'h0310] = '0; mem[16'h0311] = '0;
        run_job(3, 2, 16'h0110, 16'h0210, 16'h0310, 16'h0410, 0, 1'b0);

        mem[16'h0120] = 32'h01000000;
        mem[16'h0220] = 32'hFE800000;
        mem[16'h0320] = '0;
        run_job(1, 1, 16'h0120, 16'h0220, 16'h0320, 16'h0420, 0, 1'b0);

        run_zero(0, 3);
        run_zero(2, 0);
        run_job(2, 1, 16'h0100, 16'h0200, 16'h0300, 16'h0430, 0, 1'b0);

        fill(16'h0700, 4); fill(16'h0800, 8); fill(16'h0900, 2);
        run_job(4, 2, 16'h0700, 16'h0800, 16'h0900, 16'h0A00, 8, 1'b0);
        run_job(4, 2, 16'h0700, 16'h0800, 16'h0900, 16'h0A00, 0, 1'b0);

        fill(16'h0500, 2); fill(16'hFFFE, 2); fill(16'h0000, 2); fill(16'h0600, 2);
        run_job(2, 2, 16'h0500, 16'hFFFE, 16'h0600, 16'h0B00, 0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            int L, N;
            logic [15:0] ab, wb, bb, ob;
            L = $urandom_range(1, 5);
            N = $urandom_range(1, 4);
            ab = 16'h1000 + 16'($urandom_range(0, 255));
            wb = 16'h2000 + 16'($urandom_range(0, 255));
            bb = 16'h3000 + 16'($urandom_range(0, 255));
            ob = 16'($urandom);
            fill(ab, L); fill(wb, L * N); fill(bb, N);
            run_job(L, N, ab, wb, bb, ob, 0, r[0]);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dense_layer_sequencer.md
Name: dense_layer_sequencer

Overview:
Sequences a full dense layer (out_len neurons × in_len inputs) through the single-neuron dense MAC engine. Fetches activations, weights and biases from a 1-cycle-latency buffer memory and streams them to the engine with no gaps. Captures each neuron result and writes it to the output buffer. Sits between the layer-control registers (start/config) and the MAC engine plus buffer RAMs.

Parameters:
AW, 16, word address width of buffer memories
LW, 16, width of in_len/out_len counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; sampled only in IDLE
in_len  in  LW  inputs per neuron (L)
out_len  in  LW  neurons in layer (N)
act_base  in  AW  activation vector base address
wgt_base  in  AW  weight matrix base, row-major, N rows of L
bias_base  in  AW  bias vector base
out_base  in  AW  result vector base
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse at end of layer
err  out  1  set with done when L==0 or N==0; cleared on next accepted start
rd_en  out  1  read strobe; data returns on rd_data next cycle, never stalls
rd_addr  out  AW  read address
rd_data  in  32  read data (Q8.24)
wr_en  out  1  result write strobe
wr_addr  out  AW  result address
wr_data  out  32  result (Q8.24)
acc_data  out  32  engine dataIn
acc_valid  out  1  engine dataValid
acc_length  out  32  engine length, zero-extended latched in_len
acc_result  in  32  engine dataOut

Behaviour:
- Reset: all outputs 0; state IDLE; config latches 0. Reset mid-operation aborts with no done, no write. The engine shares reset and restarts clean.
- Engine contract: per neuron, 2L+2 consecutive valid beats: DUMMY (data 0), then a0,w0,a1,w1,…,a(L-1),w(L-1), then BIAS. acc_valid must stay high for every beat; the engine accumulates every cycle in weight/bias phases. The result is valid on acc_result exactly in the cycle after the BIAS beat.
- start in IDLE latches all config. If L==0 or N==0: next cycle done=1 and err=1, with no rd_en or acc_valid, then IDLE.
- States: IDLE -> STREAM -> DRAIN -> WRITE -> IDLE.
- STREAM is an issue stage. Each cycle it issues one slot: DUMMY (no read), ACT (rd_addr=act_ptr), WGT (rd_addr=wgt_ptr) or BIAS (rd_addr=bias_base+j).
- Present stage, one cycle later: acc_valid=1; acc_data=rd_data for reads, 0 for DUMMY. First acc_valid is 2 cycles after start.
- Neurons stream back-to-back. The DUMMY beat of neuron j+1 is presented in the same cycle as neuron j's result capture, so each neuron takes 2L+2 cycles with no bubble.
- Capture: in the cycle after the BIAS beat, register acc_result. Next cycle: wr_en=1, wr_addr=out_base+j, wr_data=captured value.
- Pointers: act_ptr resets to act_base each neuron. wgt_ptr increments continuously from wgt_base across rows, with no multiplier. All address math is modulo 2^AW.
- After the last BIAS issue: DRAIN (present bias), capture, WRITE (final wr_en), done pulse with busy falling in the same cycle.
- Total cycles from start to done: N(2L+2)+4.
- start while busy is ignored. Arithmetic overflow is the engine's; results pass through unchanged.

Optional Feature:
DENSE_SEQ_RELU_EN: when defined, wr_data = (captured[31] ? 0 : captured), i.e. ReLU fused on write. When undefined, the raw result is written. Latency is identical in both builds.

Decomposition:
- dense_seq_pkg holds:
  - state enum (IDLE, STREAM, DRAIN, WRITE)
  - beat-type enum (DUMMY, ACT, WGT, BIAS)
  - constants DW=32 and FRAC_BITS=24
- One sub-module, dense_seq_addr_gen, owns the beat-type sequencing, act/wgt/bias pointers, i/j counters and the last-beat/last-neuron flags.
- The top level owns the FSM, present stage, capture and write port.

Test Plan:
- L=2,N=1; act=[0x01000000,0x02000000], wgt=[0x00800000,0x00400000], bias=0x01000000 -> acc_valid high exactly 6 consecutive cycles; wr_data=0x02000000 at out_base; done 10 cycles after start.
- L=3,N=2, all act=1.0, row0 wgt=1.0, row1 wgt=0.5, bias 0 -> acc_valid high 16 consecutive cycles; writes 0x03000000, 0x01800000 to out_base, out_base+1; wgt addresses wgt_base..+5 in order.
- L=1,N=1, act=1.0, wgt=-1.5 (0xFE800000), bias 0 -> DENSE_SEQ_RELU_EN writes 0x00000000; without it writes 0xFE800000.
- start with in_len=0 -> done=1, err=1 next cycle; zero rd_en/acc_valid/wr_en. Next valid start clears err.
- Assert reset mid-STREAM of L=4,N=2 -> all outputs 0, no write. Rerun the same job -> results match the golden values.
- Pulse start while busy -> ignored. wgt_base=0xFFFE, L=2,N=2 -> weight addresses 0xFFFE,0xFFFF,0x0000,0x0001.
